// File: rtl/egg_timer_pkg.sv
// Purpose: shared types and defaults for the egg timer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, field width/limit defaults, display mux select codes.
package egg_timer_pkg;

  localparam int CW_DEF          = 6;
  localparam int MAX_VAL_DEF     = 59;
  localparam int ALARM_TICKS_DEF = 10;

  // Display mux select encodings
  localparam logic SEL_SET = 1'b0;
  localparam logic SEL_CNT = 1'b1;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mmss_down_counter.sv
// Purpose: minutes:seconds down counter with seconds borrow and saturation at 00:00.
// Latency: 1 cycle from load/dec to updated min/sec.
// Backpressure: none; load wins over dec, dec at 00:00 is ignored.
// Ports: clk/rst (sync, active-high), load + load_min/load_sec, dec,
//        min/sec (registered), is_one (==00:01), is_zero (==00:00).
module mmss_down_counter
  import egg_timer_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_min,
  input  logic [CW-1:0] load_sec,
  input  logic          dec,
  output logic [CW-1:0] min,
  output logic [CW-1:0] sec,
  output logic          is_one,
  output logic          is_zero
);

  logic [CW-1:0] min_q, sec_q;

  assign min     = min_q;
  assign sec     = sec_q;
  assign is_zero = (min_q == '0) && (sec_q == '0);
  assign is_one  = (min_q == '0) && (sec_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (load) begin
      min_q <= load_min;
      sec_q <= load_sec;
    end else if (dec && !is_zero) begin
      if (sec_q != '0) begin
        sec_q <= sec_q - CW'(1);
      end else begin
        // Borrow one minute; is_zero guarantees min_q > 0 here
        sec_q <= CW'(MAX_VAL);
        min_q <= min_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Purpose: egg timer main controller: SET/RUN/PAUSE/DONE sequencing, countdown, alarm timing.
// Latency: 1 cycle from sampled input pulse to every registered output.
// Backpressure: none; events are single-cycle pulses, priority clear > start_stop > tick_1hz,
//               lower-priority events in the same cycle are dropped.
// Ports: clk/rst (sync, active-high), tick_1hz, start_stop, clear, set_min/set_sec (user entry),
//        sel (0=set values, 1=countdown), cnt_min/cnt_sec, running (RUN), alarm (DONE).
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int MAX_VAL     = MAX_VAL_DEF,
  parameter int ALARM_TICKS = ALARM_TICKS_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1hz,
  input  logic          start_stop,
  input  logic          clear,
  input  logic [CW-1:0] set_min,
  input  logic [CW-1:0] set_sec,
  output logic          sel,
  output logic [CW-1:0] cnt_min,
  output logic [CW-1:0] cnt_sec,
  output logic          running,
  output logic          alarm
);

  localparam int ACW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  state_t         state_q;
  logic           sel_q, running_q, alarm_q;
  logic [ACW-1:0] alarm_cnt_q;

  logic           ld_d, dec_d;
  logic [CW-1:0]  ld_min_d, ld_sec_d;
  logic [CW-1:0]  clamp_min, clamp_sec;
  logic           set_is_zero;
  logic           cnt_is_one, cnt_is_zero;

  assign clamp_min   = (set_min > CW'(MAX_VAL)) ? CW'(MAX_VAL) : set_min;
  assign clamp_sec   = (set_sec > CW'(MAX_VAL)) ? CW'(MAX_VAL) : set_sec;
  assign set_is_zero = (clamp_min == '0) && (clamp_sec == '0);

  // Counter control: a load with zero values implements "counts zeroed"
  always_comb begin
    ld_d     = 1'b0;
    dec_d    = 1'b0;
    ld_min_d = '0;
    ld_sec_d = '0;
    case (state_q)
      ST_SET: begin
        if (clear) begin
          ld_d = 1'b1;
        end else if (start_stop && !set_is_zero) begin
          ld_d     = 1'b1;
          ld_min_d = clamp_min;
          ld_sec_d = clamp_sec;
        end
      end
      ST_RUN: begin
        if (clear)                       ld_d  = 1'b1;
        else if (!start_stop && tick_1hz) dec_d = 1'b1;
      end
      ST_PAUSE: begin
        if (clear) ld_d = 1'b1;
      end
      default: begin
        // DONE already holds 00:00; illegal states are forced to zero
        if (state_q != ST_DONE) ld_d = 1'b1;
      end
    endcase
  end

  mmss_down_counter #(
    .CW      (CW),
    .MAX_VAL (MAX_VAL)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_d),
    .load_min (ld_min_d),
    .load_sec (ld_sec_d),
    .dec      (dec_d),
    .min      (cnt_min),
    .sec      (cnt_sec),
    .is_one   (cnt_is_one),
    .is_zero  (cnt_is_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SET;
      sel_q       <= SEL_SET;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_SET: begin
          if (!clear && start_stop && !set_is_zero) begin
            state_q   <= ST_RUN;
            sel_q     <= SEL_CNT;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear) begin
            state_q   <= ST_SET;
            sel_q     <= SEL_SET;
            running_q <= 1'b0;
          end else if (start_stop) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (tick_1hz && (cnt_is_one || cnt_is_zero)) begin
            // Final tick lands on 00:00 in the counter this same edge
            state_q     <= ST_DONE;
            running_q   <= 1'b0;
            alarm_q     <= 1'b1;
            alarm_cnt_q <= '0;
          end
        end
        ST_PAUSE: begin
          if (clear) begin
            state_q <= ST_SET;
            sel_q   <= SEL_SET;
          end else if (start_stop) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (clear || start_stop ||
              (tick_1hz && alarm_cnt_q == ACW'(ALARM_TICKS - 1))) begin
            state_q     <= ST_SET;
            sel_q       <= SEL_SET;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
          end else if (tick_1hz) begin
            alarm_cnt_q <= alarm_cnt_q + ACW'(1);
          end
        end
        default: begin
          state_q     <= ST_SET;
          sel_q       <= SEL_SET;
          running_q   <= 1'b0;
          alarm_q     <= 1'b0;
          alarm_cnt_q <= '0;
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Purpose: self-checking bench for egg_timer_ctrl against a remaining-seconds reference model.
// Latency: checks every output 1 ns after each rising edge.
// Backpressure: n/a.
module tb_egg_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] set_min = '0;
  logic [5:0] set_sec = '0;
  logic       sel, running, alarm;
  logic [5:0] cnt_min, cnt_sec;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=set 1=run 2=pause 3=done, remaining time in whole seconds
  int m_mode  = 0;
  int m_rem   = 0;
  int m_ticks = 0;

  always #5 clk = ~clk;

  egg_timer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .start_stop (start_stop),
    .clear      (clear),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .sel        (sel),
    .cnt_min    (cnt_min),
    .cnt_sec    (cnt_sec),
    .running    (running),
    .alarm      (alarm)
  );

  function automatic int clamp59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic model_step(input bit r, input bit ss, input bit clr, input bit tk,
                            input int smin, input int ssec);
    int t;
    if (r) begin
      m_mode = 0; m_rem = 0; m_ticks = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (clr) m_rem = 0;
        else if (ss) begin
          t = clamp59(smin) * 60 + clamp59(ssec);
          if (t > 0) begin m_rem = t; m_mode = 1; end
        end
      end
      1: begin
        if (clr) begin m_mode = 0; m_rem = 0; end
        else if (ss) m_mode = 2;
        else if (tk) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_mode = 3; m_ticks = 0; end
        end
      end
      2: begin
        if (clr) begin m_mode = 0; m_rem = 0; end
        else if (ss) m_mode = 1;
      end
      default: begin
        if (clr || ss) m_mode = 0;
        else if (tk) begin
          m_ticks++;
          if (m_ticks == 10) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check(input string tag);
    logic       e_sel, e_run, e_alm;
    logic [5:0] e_min, e_sec;
    e_sel = (m_mode != 0);
    e_run = (m_mode == 1);
    e_alm = (m_mode == 3);
    e_min = 6'(m_rem / 60);
    e_sec = 6'(m_rem % 60);
    tests++;
    assert (sel === e_sel) else begin
      fails++; $error("FAIL %s sel got %b exp %b", tag, sel, e_sel);
    end
    tests++;
    assert (running === e_run) else begin
      fails++; $error("FAIL %s running got %b exp %b", tag, running, e_run);
    end
    tests++;
    assert (alarm === e_alm) else begin
      fails++; $error("FAIL %s alarm got %b exp %b", tag, alarm, e_alm);
    end
    tests++;
    assert ({cnt_min, cnt_sec} === {e_min, e_sec}) else begin
      fails++; $error("FAIL %s cnt got %0d:%0d exp %0d:%0d", tag, cnt_min, cnt_sec, e_min, e_sec);
    end
  endtask

  // One clock cycle with the given inputs, then model update and check
  task automatic step(input bit r, input bit ss, input bit clr, input bit tk,
                      input int smin, input int ssec, input string tag);
    rst = r; start_stop = ss; clear = clr; tick_1hz = tk;
    set_min = 6'(smin); set_sec = 6'(ssec);
    @(posedge clk);
    #1;
    model_step(r, ss, clr, tk, smin, ssec);
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
    check(tag);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 1, 0, 0, "set_tick_ignored");

    // 01:00 start, first tick borrows to 00:59
    step(0, 1, 0, 0, 1, 0, "load_0100");
    step(0, 0, 0, 1, 1, 0, "tick_0059");
    step(0, 0, 1, 0, 1, 0, "clear_run");

    // 00:02 to DONE, then alarm lasts exactly 10 ticks
    step(0, 1, 0, 0, 0, 2, "load_0002");
    step(0, 0, 0, 1, 0, 2, "tick_0001");
    step(0, 0, 0, 1, 0, 2, "tick_done");
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 2, "done_idle");
      step(0, 0, 0, 1, 0, 2, "alarm_tick");
    end
    step(0, 0, 0, 0, 0, 2, "after_alarm");

    // Pause freezes counts
    step(0, 1, 0, 0, 0, 5, "load_0005");
    step(0, 0, 0, 1, 0, 5, "tick_0004");
    step(0, 1, 0, 0, 0, 5, "pause");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 5, "pause_tick");
    step(0, 1, 0, 0, 0, 5, "resume");
    step(0, 0, 0, 1, 0, 5, "tick_0003");
    step(0, 0, 1, 0, 0, 5, "clear_run2");

    // 00:00 start ignored, out-of-range set clamps to 59:59
    step(0, 1, 0, 0, 0, 0, "start_zero");
    step(0, 1, 0, 0, 63, 63, "load_clamp");
    step(0, 0, 0, 1, 63, 63, "tick_clamp");
    step(0, 0, 1, 0, 63, 63, "clear_clamp");
    step(0, 1, 0, 0, 60, 0, "load_60_0");
    step(0, 0, 1, 0, 60, 0, "clear_60_0");

    // clear beats tick at 00:01
    step(0, 1, 0, 0, 0, 1, "load_0001");
    step(0, 0, 1, 1, 0, 1, "clear_vs_tick");
    step(0, 0, 0, 1, 0, 1, "set_after");

    // start_stop beats tick at 02:00
    step(0, 1, 0, 0, 2, 0, "load_0200");
    step(0, 1, 0, 1, 2, 0, "ss_vs_tick");
    step(0, 0, 0, 1, 2, 0, "paused_0200");
    step(0, 1, 0, 0, 2, 0, "resume_0200");
    step(0, 0, 1, 0, 2, 0, "clear_0200");

    // Reset in DONE; set change in DONE has no effect
    step(0, 1, 0, 0, 0, 1, "load_0001b");
    step(0, 0, 0, 1, 9, 9, "tick_done2");
    step(0, 0, 0, 1, 9, 9, "done_tick1");
    step(1, 0, 0, 0, 9, 9, "reset_done");

    // start_stop exits DONE immediately
    step(0, 1, 0, 0, 0, 1, "load_0001c");
    step(0, 0, 0, 1, 0, 1, "tick_done3");
    step(0, 1, 0, 0, 0, 1, "ss_exit_done");

    // Randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, ss, clr, tk;
      int smin, ssec;
      r    = ($urandom_range(0, 499) == 0);
      ss   = ($urandom_range(0, 11) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      tk   = ($urandom_range(0, 2) == 0);
      smin = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 1);
      ssec = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
      step(r, ss, clr, tk, smin, ssec, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
